// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: Q = A - B - Cwe, one bit per clock, LSB first.
// One full-subtractor slice with a borrow flop serves the whole word.
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cwe_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] q_o,
    output logic         cwy_o
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       ra_q, ra_d;
    logic [N-1:0]       rb_q, rb_d;
    logic [N-2:0]       rq_q, rq_d;
    logic [N-1:0]       q_q, q_d;
    logic               br_q, br_d;
    logic               cwy_q, cwy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               diff_bit;
    logic               borrow_bit;
    logic [N-1:0]       rq_shift;

    // Full-subtractor cell on the current LSBs; rq_shift is the work
    // register after absorbing this bit, which is the full result on the last bit.
    always_comb begin
        diff_bit   = ra_q[0] ^ rb_q[0] ^ br_q;
        borrow_bit = (~ra_q[0] & (rb_q[0] | br_q)) | (rb_q[0] & br_q);
        rq_shift   = {diff_bit, rq_q};

        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rq_d    = rq_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        cwy_d   = cwy_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ra_d    = a_i;
                    rb_d    = b_i;
                    br_d    = cwe_i;
                    rq_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ra_d = {1'b0, ra_q[N-1:1]};
                rb_d = {1'b0, rb_q[N-1:1]};
                br_d = borrow_bit;
                rq_d = rq_shift[N-1:1];
                if (cnt_q == CNT_W'(N - 1)) begin
                    q_d     = rq_shift;
                    cwy_d   = borrow_bit;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rq_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            cwy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rq_q    <= rq_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            cwy_q   <= cwy_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign q_o    = q_q;
    assign cwy_o  = cwy_q;

endmodule
